delay_line_meter: RTL and testbench
===================================

Name: delay_line_meter

Overview:
- Sequential characterisation controller for the 8-tap programmable delay line.
- Drives the delay line's 3-bit tap select. Enables a ring oscillator that is closed externally around the line: line_in = osc_en AND NOT line_out.
- For each tap, counts oscillator rising edges over a fixed gate window, then streams one (tap, count) result per tap over a valid/ready interface.
- Sits beside the delay line in the ALFSR top level; results feed the readout/configuration logic.

Parameters:
- CNT_W, 16, width of the edge counter and of res_count.
- GATE_CYCLES, 1024, clk cycles per measurement window (>= 1).
- SETTLE_CYCLES, 16, clk cycles between oscillator enable and window start, so the ring settles (>= 2, which covers synchroniser latency).

Ports:
- clk  input  1  system clock (digitalization clock); all state on its rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin an 8-tap sweep; ignored while busy=1.
- osc_in  input  1  delay line output (line_out); asynchronous to clk.
- sel  output  3  tap select to the delay line; sel[0]=s0, sel[1]=s1, sel[2]=s2.
- osc_en  output  1  ring oscillator enable.
- busy  output  1  high from the cycle after an accepted start until done.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts the result when res_valid and res_ready are both high in the same cycle.
- res_tap  output  3  tap index of the current result.
- res_count  output  CNT_W  rising-edge count for that tap.
- done  output  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, sel=0, osc_en=0, busy=0, res_valid=0, res_tap=0, res_count=0, done=0, tap=0, counters=0, synchroniser flops=0. Reset mid-sweep aborts the sweep immediately; no partial result is emitted.
- osc_in path: 2-flop synchroniser, then a previous-value flop. A rising edge is sync2=1 AND prev=0. Valid only when the oscillator frequency is below clk/2; faster rings alias. Counting faster rings is out of scope.
- IDLE:
  - osc_en=0, busy=0.
  - When start=1: tap<=0, sel<=0, go to SETTLE.
- SETTLE:
  - osc_en=1, busy=1.
  - Waits SETTLE_CYCLES cycles, then clears the edge count and enters GATE.
- GATE:
  - osc_en=1.
  - Each detected edge increments the count. The count saturates at 2^CNT_W-1 and does not wrap.
  - After exactly GATE_CYCLES cycles: res_count<=count, res_tap<=tap, res_valid<=1, osc_en<=0, go to REPORT.
  - An edge detected in the last GATE cycle is counted.
- REPORT:
  - osc_en=0.
  - res_valid, res_tap and res_count are held stable until res_valid and res_ready are both high in the same cycle. res_ready may already be high on entry.
  - On acceptance: res_valid<=0.
  - If tap=7: go to DONE.
  - Otherwise: tap<=tap+1, sel<=tap+1, go to SETTLE.
- sel changes only while osc_en=0, so no tap switch happens while the ring runs.
- DONE: done=1 for one cycle, busy<=0, return to IDLE.
- Back-to-back sweep: start asserted in the same cycle as done is ignored. start is accepted from the cycle after done.
- Sweep latency with res_ready tied high: 8*(SETTLE_CYCLES+GATE_CYCLES+1)+2 cycles from start to the done pulse, ±1 for the start and done edges.
- res_count is unsigned. No arithmetic beyond increment with saturation.

Decomposition:
- Shared package:
  - state enum: IDLE, SETTLE, GATE, REPORT, DONE.
  - NUM_TAPS=8, TAP_W=3.
  - Default CNT_W, GATE_CYCLES and SETTLE_CYCLES constants.
- One sub-module: osc_edge_sync. It holds the 2-flop synchroniser plus rising-edge detect, and is reusable for other asynchronous ring inputs.
- The FSM, cycle timer, and saturating counter stay in delay_line_meter.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst for 3 cycles while toggling osc_in, then release without start.
  - Required: all outputs 0, busy=0, no res_valid.
- Basic sweep:
  - Stimulus: model osc_in as a square wave with period 8 clk when osc_en=1 (tap-independent); GATE_CYCLES=1024, res_ready=1; pulse start.
  - Required: 8 results with res_tap 0..7, each res_count=128±1; done pulses once; sel equals res_tap during the measurement that produced it.
- Tap-dependent model:
  - Stimulus: oscillator period = 4+2*sel clk.
  - Required: counts 256, 170, 128, 102, 85, 73, 64, 56 (±1); the counts decrease monotonically with tap.
- Backpressure:
  - Stimulus: res_ready low for 50 cycles on tap 3.
  - Required: res_valid, res_tap=3 and res_count held stable; osc_en=0 and sel=3 throughout; the sweep resumes after acceptance.
- Saturation:
  - Stimulus: CNT_W=4, period 4 clk, GATE_CYCLES=1024.
  - Required: every res_count=15.
- Abort:
  - Stimulus: assert rst during GATE of tap 5, then start again.
  - Required: immediate return to the reset values; the new sweep starts at tap 0 with correct counts; start is ignored while busy.

Source files
------------

// File: rtl/delay_line_meter_pkg.sv
// rtl/delay_line_meter_pkg.sv - shared types and constants for the delay line meter
package delay_line_meter_pkg;

  localparam int NUM_TAPS              = 8;
  localparam int TAP_W                 = 3;
  localparam int DEF_CNT_W             = 16;
  localparam int DEF_GATE_CYCLES       = 1024;
  localparam int DEF_SETTLE_CYCLES     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    GATE   = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/delay_line_meter_osc_edge_sync.sv
// rtl/delay_line_meter_osc_edge_sync.sv - 2-flop synchroniser with rising-edge detect
module osc_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Bring the asynchronous ring output into the clk domain and keep one
  // cycle of history so a 0->1 transition shows up as a single-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/delay_line_meter.sv
// rtl/delay_line_meter.sv - per-tap ring oscillator edge counter with result stream
module delay_line_meter
  import delay_line_meter_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_in,
  output logic [TAP_W-1:0] sel,
  output logic             osc_en,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAP_W-1:0] res_tap,
  output logic [CNT_W-1:0] res_count,
  output logic             done
);

  // One timer serves both the settle and the gate window.
  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);

  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [TAP_W-1:0]   tap_q;
  logic [TAP_W-1:0]   sel_q;
  logic               osc_en_q;
  logic               busy_q;
  logic               res_valid_q;
  logic [TAP_W-1:0]   res_tap_q;
  logic [CNT_W-1:0]   res_count_q;
  logic               done_q;
  logic               rise;

  osc_edge_sync u_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (osc_in),
    .rise_o  (rise)
  );

  // Saturating edge count: holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sweep sequencer: settle, gate, report for each tap, then pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      tap_q       <= '0;
      sel_q       <= '0;
      osc_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_tap_q   <= '0;
      res_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tap_q    <= '0;
            sel_q    <= '0;
            timer_q  <= '0;
            osc_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            timer_q <= '0;
            cnt_q   <= '0;
            state_q <= GATE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        GATE: begin
          cnt_q <= cnt_d;
          if (timer_q == GATE_LAST) begin
            // cnt_d already includes an edge seen in this final cycle.
            timer_q     <= '0;
            res_count_q <= cnt_d;
            res_tap_q   <= tap_q;
            res_valid_q <= 1'b1;
            osc_en_q    <= 1'b0;
            state_q     <= REPORT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        REPORT: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            if (tap_q == LAST_TAP) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // The ring is stopped here, so the tap may switch safely.
              tap_q    <= tap_q + TAP_W'(1);
              sel_q    <= tap_q + TAP_W'(1);
              osc_en_q <= 1'b1;
              state_q  <= SETTLE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign osc_en    = osc_en_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_tap   = res_tap_q;
  assign res_count = res_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_delay_line_meter.sv
// tb/tb_delay_line_meter.sv - directed self-checking bench for delay_line_meter
module tb_delay_line_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_s;
  logic        res_ready;
  wire         osc_in;
  logic [2:0]  sel;
  logic        osc_en;
  logic        busy;
  logic        res_valid;
  logic [2:0]  res_tap;
  logic [15:0] res_count;
  logic        done;

  wire         osc_in_s;
  logic [2:0]  s_sel;
  logic        s_osc_en;
  logic        s_busy;
  logic        s_valid;
  logic [2:0]  s_tap;
  logic [3:0]  s_count;
  logic        s_done;

  logic tog_en;
  logic tog;
  logic osc_m;
  logic osc_s_m;
  int   osc_mode;
  int   ph;
  int   ph_s;
  int   per;

  int n_checks;
  int n_errors;
  int exp_cnt [8];
  int gate_sel;
  int sel_glitch;
  bit prev_en;
  int prev_sel;
  int s_next;
  int s_done_cnt;

  always #5 clk = ~clk;

  assign osc_in   = tog_en ? tog : osc_m;
  assign osc_in_s = osc_s_m;

  delay_line_meter #(.CNT_W(16), .GATE_CYCLES(1024), .SETTLE_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .osc_in    (osc_in),
    .sel       (sel),
    .osc_en    (osc_en),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_tap   (res_tap),
    .res_count (res_count),
    .done      (done)
  );

  delay_line_meter #(.CNT_W(4), .GATE_CYCLES(1024), .SETTLE_CYCLES(16)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .osc_in    (osc_in_s),
    .sel       (s_sel),
    .osc_en    (s_osc_en),
    .busy      (s_busy),
    .res_valid (s_valid),
    .res_ready (res_ready),
    .res_tap   (s_tap),
    .res_count (s_count),
    .done      (s_done)
  );

  task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Ring models: square waves that run only while the matching osc_en is high.
  always @(negedge clk) begin
    if (!osc_en) begin
      ph    = 0;
      osc_m = 1'b0;
    end else begin
      per   = (osc_mode == 0) ? 8 : 4 + 2 * int'(sel);
      osc_m = (ph < per / 2);
      ph    = (ph + 1 >= per) ? 0 : ph + 1;
    end
    if (!s_osc_en) begin
      ph_s    = 0;
      osc_s_m = 1'b0;
    end else begin
      osc_s_m = (ph_s < 2);
      ph_s    = (ph_s + 1 >= 4) ? 0 : ph_s + 1;
    end
  end

  // Track the tap used during measurement and any tap switch while running.
  always @(negedge clk) begin
    if (osc_en) gate_sel = int'(sel);
    if (osc_en && prev_en && int'(sel) != prev_sel) sel_glitch++;
    prev_en  = osc_en;
    prev_sel = int'(sel);
  end

  // Saturating instance results.
  always @(negedge clk) begin
    if (!rst && s_valid && res_ready) begin
      check("sat_count", s_count, 15);
      check("sat_tap", s_tap, s_next);
      s_next++;
    end
    if (!rst && s_done) s_done_cnt++;
  end

  task automatic sweep(input int mode, input int bp_tap);
    int waited;
    int prev;
    int bp_bad;
    prev     = 0;
    osc_mode = mode;
    @(negedge clk);
    start   = 1'b1;
    start_s = (mode == 0);
    @(negedge clk);
    start   = 1'b0;
    start_s = 1'b0;
    check("busy_on", busy, 1);
    for (int t = 0; t < 8; t++) begin
      waited = 0;
      while (!res_valid && waited < 3000) begin
        @(negedge clk);
        waited++;
      end
      if (!res_valid) begin
        check("res_timeout", 0, 1);
        return;
      end
      check("res_tap", res_tap, t);
      check("res_count", res_count, exp_cnt[t], 1);
      check("gate_sel", gate_sel, t);
      if (mode == 1 && t > 0) check("monotonic", (int'(res_count) < prev), 1);
      prev = int'(res_count);
      if (t == bp_tap) begin
        res_ready = 1'b0;
        bp_bad    = 0;
        for (int c = 0; c < 50; c++) begin
          start = (c == 10);
          @(negedge clk);
          if (!res_valid || int'(res_tap) != t || int'(res_count) != prev || osc_en || int'(sel) != t)
            bp_bad++;
        end
        start = 1'b0;
        check("bp_hold", bp_bad, 0);
        res_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_clear", done, 0);
    check("busy_off", busy, 0);
    @(negedge clk);
    check("restart_ignored", busy, 0);
  endtask

  initial begin
    int waited;
    n_checks   = 0;
    n_errors   = 0;
    sel_glitch = 0;
    s_next     = 0;
    s_done_cnt = 0;
    osc_mode   = 0;
    ph         = 0;
    ph_s       = 0;
    osc_m      = 1'b0;
    osc_s_m    = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    start_s    = 1'b0;
    res_ready  = 1'b1;
    tog_en     = 1'b1;
    tog        = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tog = ~tog;
    end
    rst    = 1'b0;
    tog_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_osc_en", osc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_tap", res_tap, 0);
    check("rst_count", res_count, 0);
    check("rst_done", done, 0);

    for (int i = 0; i < 8; i++) exp_cnt[i] = 128;
    sweep(0, -1);
    repeat (4) @(negedge clk);
    check("sat_results", s_next, 8);
    check("sat_done", s_done_cnt, 1);

    exp_cnt = '{256, 170, 128, 102, 85, 73, 64, 56};
    sweep(1, 3);

    osc_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (!(osc_en && sel == 3'd5) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reach_tap5", (osc_en && sel == 3'd5), 1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sel", sel, 0);
    check("abort_osc_en", osc_en, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", res_valid, 0);
    check("abort_count", res_count, 0);
    rst = 1'b0;
    @(negedge clk);
    sweep(1, -1);

    check("sel_stable", sel_glitch, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
